// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with a registered result over valid/ready.
// Logic, arithmetic and compare ops finish in one cycle; shifts run one bit
// position per cycle.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   aluop                 4-bit op code from the ALU control decoder
//   arith                 1001 only: 1 = SRA, 0 = SRL
//   is_unsigned           0111/1011 only: 1 = unsigned compare
//   operand_a, operand_b  operands; operand_b low log2(WIDTH) bits = shift amount
//   out_valid / out_ready result handshake; out_valid is high only in DONE
//   result, zero          registered result and its zero flag

module alu_seq_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluop,
    input  logic             arith,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_LT  = 4'b0111,
        OP_SLL = 4'b1000,
        OP_SRX = 4'b1001,
        OP_XOR = 4'b1010,
        OP_GE  = 4'b1011,
        OP_EQ  = 4'b1110
    } alu_op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;   // 1 = SLL, 0 = right shift
    logic             arith_q, arith_d;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             lt_flag;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;

    assign shamt    = operand_b[SHW-1:0];
    assign is_shift = (aluop == OP_SLL) || (aluop == OP_SRX);

    // Single-cycle datapath, evaluated on the live inputs at accept.
    always_comb begin
        if (is_unsigned) begin
            lt_flag = operand_a < operand_b;
        end else begin
            lt_flag = $signed(operand_a) < $signed(operand_b);
        end
    end

    always_comb begin
        alu_res = '0;
        case (aluop)
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_ADD:  alu_res = operand_a + operand_b;
            OP_SUB:  alu_res = operand_a - operand_b;
            OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, lt_flag};
            OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, ~lt_flag};
            OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, operand_a == operand_b};
            default: alu_res = '0;
        endcase
    end

    // One-bit step of the iterative shifter; SRA replicates the current MSB.
    always_comb begin
        if (left_q) begin
            shifted = {work_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        arith_d  = arith_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    left_d  = (aluop == OP_SLL);
                    arith_d = arith;
                    if (!is_shift) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = DONE;
                    end else if (shamt == '0) begin
                        result_d = operand_a;
                        zero_d   = (operand_a == '0);
                        state_d  = DONE;
                    end else begin
                        work_d  = operand_a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = shifted;
                    zero_d   = (shifted == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed self-checking bench for alu_seq_exec.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_alu_seq_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluop;
    logic        arith;
    logic        is_unsigned;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_tests;
    int n_fail;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluop       (aluop),
        .arith       (arith),
        .is_unsigned (is_unsigned),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge; returns at the falling edge after accept.
    task automatic issue(input logic [3:0] op, input logic ar, input logic uns,
                         input logic [31:0] a, input logic [31:0] b);
        chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
        aluop       = op;
        arith       = ar;
        is_unsigned = uns;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(negedge clk);
        in_valid    = 1'b0;
    endtask

    // Bounded wait for out_valid; latency counted in cycles after the accept edge.
    task automatic wait_valid(input string tag, input int exp_lat, input bit scramble);
        int lat;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (scramble) begin
                operand_a = $urandom;
                operand_b = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    // Take the result with one cycle of out_ready, then confirm return to IDLE.
    task automatic collect(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic ar, input logic uns,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_zero,
                       input int exp_lat, input bit scramble);
        issue(op, ar, uns, a, b);
        wait_valid(tag, exp_lat, scramble);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        collect(tag);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        aluop       = 4'b0000;
        arith       = 1'b0;
        is_unsigned = 1'b0;
        operand_a   = '0;
        operand_b   = '0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Arithmetic and wrap
        run("add_wrap", 4'b0010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1, 1'b0);
        run("sub_neg",  4'b0110, 1'b0, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);
        run("and",      4'b0000, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1, 1'b0);
        run("or",       4'b0001, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1, 1'b0);

        // Compares
        run("lt_s",  4'b0111, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b0);
        run("lt_u",  4'b0111, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);
        run("ge_s",  4'b1011, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1, 1'b0);
        run("ge_u",  4'b1011, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b0);
        run("ge_eq", 4'b1011, 1'b0, 1'b0, 32'd9, 32'd9, 32'd1, 1'b0, 1, 1'b0);
        run("eq",    4'b1110, 1'b0, 1'b0, 32'd7, 32'd7, 32'd1, 1'b0, 1, 1'b0);
        run("eq_ne", 4'b1110, 1'b0, 1'b0, 32'd7, 32'd8, 32'd0, 1'b1, 1, 1'b0);
        run("undef", 4'b0011, 1'b0, 1'b0, 32'd7, 32'd8, 32'd0, 1'b1, 1, 1'b0);

        // Shifts (0x24 checks that only the low 5 bits count)
        run("sra4",   4'b1001, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5, 1'b0);
        run("srl4",   4'b1001, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 5, 1'b0);
        run("sll0",   4'b1000, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1, 1'b0);
        run("sll31",  4'b1000, 1'b0, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 32, 1'b0);
        run("sll_out", 4'b1000, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'h0, 1'b1, 2, 1'b0);

        // Operand isolation during SHIFT
        run("iso_sll8", 4'b1000, 1'b0, 1'b0, 32'h3, 32'd8, 32'h300, 1'b0, 9, 1'b1);

        // Backpressure with an ignored request while in DONE
        issue(4'b1010, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0);
        wait_valid("bp_xor", 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                aluop     = 4'b0010;
                operand_a = 32'd100;
                operand_b = 32'd200;
                in_valid  = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            chk("bp_result", result, 32'hFF00);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        collect("bp_release");
        @(negedge clk);
        chk("bp_no_queue", {31'd0, out_valid}, 32'd0);

        // Reset during a shift aborts it; result from the prior op is cleared
        run("pre_rst", 4'b0110, 1'b0, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1'b0);
        issue(4'b1000, 1'b0, 1'b0, 32'h1, 32'd20);
        repeat (5) @(negedge clk);
        chk("mid_shift_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_shift_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_result", result, 32'd0);
        chk("mrst_zero", {31'd0, zero}, 32'd1);
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("post_rst_add", 4'b0010, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Execute-stage ALU that consumes the 4-bit ALU operation code produced by the core's ALU control decoder and returns a registered result over a valid/ready handshake. Logic, arithmetic and compare ops complete in one cycle. Shifts run iteratively, one bit position per cycle, so the core can trade shift latency for area. It sits between the decode/control stage (op code, operands) and writeback/branch resolution (result, zero flag).

## Interface
- WIDTH, 32, datapath width; shift amount uses the low log2(WIDTH) bits of operand_b (5 for 32)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept an op; high only in IDLE
- aluop  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 LT, 1000 SLL, 1001 SRL/SRA, 1010 XOR, 1011 GE, 1110 EQ
- arith  in  1  for 1001: 1 = SRA, 0 = SRL; ignored otherwise
- is_unsigned  in  1  for 0111/1011: 1 = unsigned compare, 0 = signed
- operand_a  in  WIDTH  first operand, shift source
- operand_b  in  WIDTH  second operand, shift amount source
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  high when result == 0, registered with result

## Operation
- States: IDLE, SHIFT, DONE.
- Accept occurs when in_valid && in_ready.
- At accept, latch aluop, arith, is_unsigned, operand_a, operand_b and shamt = operand_b[log2(WIDTH)-1:0]. Input changes after accept have no effect.
- Non-shift op at accept: compute from the inputs, register result and zero, go to DONE.
- AND, OR, XOR: bitwise.
- ADD, SUB: modulo 2^WIDTH, carry/borrow discarded.
- LT: 1 if a < b, else 0.
- GE: 1 if a >= b, else 0.
- EQ: 1 if a == b, else 0.
- LT and GE compare signed unless is_unsigned. Compare results are zero-extended to WIDTH.
- Undefined op codes: result 0, zero 1, one cycle like other non-shift ops.
- Shift op with shamt = 0: result = operand_a, go to DONE.
- Shift op with shamt > 0: load a working register with operand_a and a down-counter with shamt, go to SHIFT.
- In SHIFT, each cycle:
  - shift the working register one bit;
  - SLL fills with 0; SRL fills with 0; SRA fills with the current MSB;
  - decrement the counter;
  - when the counter reaches 0, go to DONE with result = working register.
- DONE: out_valid = 1. result and zero are held stable until out_ready. When out_valid && out_ready, go to IDLE.
- in_ready is low in SHIFT and DONE. Requests there are ignored, not queued.

## Timing
- Reset (async assert, any state): state IDLE, in_ready 1, out_valid 0, result 0, zero 1, counter 0. A shift in progress is aborted with no output.
- Non-shift and shamt-0 latency: out_valid rises the cycle after accept.
- Shift latency: out_valid rises shamt+1 cycles after accept; maximum WIDTH cycles.
- out_ready held high: result leaves in the first DONE cycle. in_ready rises the following cycle.
- Minimum issue interval is 2 cycles; no back-to-back accepts.
- out_valid must not drop, and result must not change, while out_ready is low.
- out_ready asserted outside DONE has no effect.

## Test plan
- Reset mid-operation: assert rst_n=0 during SHIFT of 0x1 SLL 20 -> out_valid 0, result 0, zero 1, in_ready 1; after release, ADD 2+3 -> result 5 one cycle after accept.
- Arithmetic and wrap: ADD 0xFFFFFFFF+1 -> 0, zero 1; SUB 5-7 -> 0xFFFFFFFE, zero 0; each out_valid one cycle after accept.
- Signed/unsigned compares with a=0xFFFFFFFF, b=1: LT signed -> 1, LT unsigned -> 0; GE signed -> 0, GE unsigned -> 1; EQ 7,7 -> 1.
- Shift timing: 0x80000000 SRA 4 -> 0xF8000000, out_valid 5 cycles after accept; SRL 4 -> 0x08000000; SLL by 0 -> operand_a after 1 cycle; SLL by 31 of 0x1 -> 0x80000000 after 32 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after XOR 0xF0F0^0x0FF0 -> result 0xFF00 stable, out_valid high, in_ready low, a new in_valid ignored; release -> in_ready high the next cycle.
- Operand isolation: change operand_a/operand_b every cycle during SHIFT of 0x3 SLL 8 -> result 0x300 unaffected.
